// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares the asynchronous FIFO write port among NUM_REQ
// requesters in the w_clk domain. Grants are round-robin at burst granularity;
// a grant lasts until the grantee's last word, MAX_BURST words, or an abort.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 8,
  parameter int CW        = 8
) (
  input  logic                  w_clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic                  full_flag,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  w_en,
  output logic [DW-1:0]         w_data,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic [15:0]           stat_bursts,
  output logic [15:0]           stat_stalls
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [2:0]       last;
  logic [CW-1:0]    count;

  logic             req_g;
  logic             last_g;
  logic             acc;
  logic             cap_hit;
  logic             release_burst;
  logic             any_req;
  logic [2:0]       sel;
  logic [2:0]       sel_hi;
  logic [2:0]       sel_lo;
  logic             hi_found;

  // Grantee-qualified request, accept and release decisions
  always_comb begin
    req_g         = |(req & gnt);
    last_g        = |(req_last & gnt);
    acc           = (state == BURST) && req_g && !full_flag;
    cap_hit       = (count == CW'(MAX_BURST - 1));
    release_burst = (state == BURST) && ((acc && (last_g || cap_hit)) || !req_g);
    w_en          = acc;
    ack           = acc ? gnt : '0;
  end

  // Data mux driven by the one-hot grant
  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) w_data = req_data[i*DW +: DW];
    end
  end

  // Round-robin pick: lowest requester above last, else lowest overall
  always_comb begin
    any_req  = |req;
    sel_hi   = '0;
    sel_lo   = '0;
    hi_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_lo = 3'(i);
        if (i > int'(last)) begin
          sel_hi   = 3'(i);
          hi_found = 1'b1;
        end
      end
    end
    sel = hi_found ? sel_hi : sel_lo;
  end

  // Arbitration FSM with registered grant, grant_id and busy
  always_ff @(posedge w_clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      count    <= '0;
      last     <= 3'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
            grant_id <= sel;
            busy     <= 1'b1;
            count    <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (release_burst) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            last  <= grant_id;
          end else if (acc) begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] bursts_q;
  logic [15:0] stalls_q;

  // Saturating counters for completed bursts and full-stall cycles
  always_ff @(posedge w_clk) begin
    if (rst) begin
      bursts_q <= '0;
      stalls_q <= '0;
    end else begin
      if (release_burst && (acc || count != '0) && bursts_q != 16'hFFFF)
        bursts_q <= bursts_q + 16'd1;
      if ((state == BURST) && req_g && full_flag && stalls_q != 16'hFFFF)
        stalls_q <= stalls_q + 16'd1;
    end
  end

  assign stat_bursts = bursts_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_bursts = 16'd0;
  assign stat_stalls = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed vectors with hand-computed expectations for
// fifo_write_arbiter at default parameters (NUM_REQ=4, DW=8, MAX_BURST=8).
module tb_fifo_write_arbiter;

  logic        w_clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic        full_flag = 1'b0;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        w_en;
  logic [7:0]  w_data;
  logic [2:0]  grant_id;
  logic        busy;
  logic [15:0] stat_bursts;
  logic [15:0] stat_stalls;

  int compared = 0;
  int mismatched = 0;

  fifo_write_arbiter dut (
    .w_clk(w_clk), .rst(rst), .req(req), .req_data(req_data),
    .req_last(req_last), .full_flag(full_flag), .gnt(gnt), .ack(ack),
    .w_en(w_en), .w_data(w_data), .grant_id(grant_id), .busy(busy),
    .stat_bursts(stat_bursts), .stat_stalls(stat_stalls)
  );

  // Free-running write clock
  always #5 w_clk = ~w_clk;

  function automatic logic [31:0] pack4(input logic [7:0] d3, input logic [7:0] d2,
                                        input logic [7:0] d1, input logic [7:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, settle, then checks may run
  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d,
                               input logic [3:0] l, input logic f);
    @(posedge w_clk);
    #1;
    req       = r;
    req_data  = d;
    req_last  = l;
    full_flag = f;
    #1;
  endtask

  task automatic doReset();
    @(posedge w_clk);
    #1;
    rst = 1'b1;
    req = '0;
    req_last = '0;
    full_flag = 1'b0;
    @(posedge w_clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    doReset();
    applyStimulus(4'b0000, 32'h0, 4'b0000, 1'b0);
    checkOutput("rst_gnt", 32'(gnt), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_gid", 32'(grant_id), 32'h0);
    checkOutput("rst_wen", 32'(w_en), 32'h0);
    checkOutput("rst_ack", 32'(ack), 32'h0);
    checkOutput("rst_stat_b", 32'(stat_bursts), 32'h0);
    checkOutput("rst_stat_s", 32'(stat_stalls), 32'h0);

    $display("[TB] single requester, 3-word packet");
    applyStimulus(4'b0010, pack4(8'h0, 8'h0, 8'h11, 8'h0), 4'b0000, 1'b0);
    checkOutput("p3_idle_gnt", 32'(gnt), 32'h0);
    checkOutput("p3_idle_wen", 32'(w_en), 32'h0);
    applyStimulus(4'b0010, pack4(8'h0, 8'h0, 8'h11, 8'h0), 4'b0000, 1'b0);
    checkOutput("p3_gnt", 32'(gnt), 32'h2);
    checkOutput("p3_wen0", 32'(w_en), 32'h1);
    checkOutput("p3_data0", 32'(w_data), 32'h11);
    checkOutput("p3_ack0", 32'(ack), 32'h2);
    applyStimulus(4'b0010, pack4(8'h0, 8'h0, 8'h22, 8'h0), 4'b0000, 1'b0);
    checkOutput("p3_wen1", 32'(w_en), 32'h1);
    checkOutput("p3_data1", 32'(w_data), 32'h22);
    applyStimulus(4'b0010, pack4(8'h0, 8'h0, 8'h33, 8'h0), 4'b0010, 1'b0);
    checkOutput("p3_wen2", 32'(w_en), 32'h1);
    checkOutput("p3_data2", 32'(w_data), 32'h33);
    applyStimulus(4'b0000, 32'h0, 4'b0000, 1'b0);
    checkOutput("p3_rel_gnt", 32'(gnt), 32'h0);
    checkOutput("p3_rel_busy", 32'(busy), 32'h0);
    checkOutput("p3_rel_gid", 32'(grant_id), 32'h1);
    checkOutput("p3_rel_wen", 32'(w_en), 32'h0);

    $display("[TB] round-robin fairness");
    doReset();
    applyStimulus(4'b1111, pack4(8'hA3, 8'hA2, 8'hA1, 8'hA0), 4'b1111, 1'b0);
    checkOutput("rr_idle_busy", 32'(busy), 32'h0);
    for (int n = 0; n < 5; n++) begin
      applyStimulus(4'b1111, pack4(8'hA3, 8'hA2, 8'hA1, 8'hA0), 4'b1111, 1'b0);
      checkOutput($sformatf("rr_gnt%0d", n), 32'(gnt), 32'(1 << (n % 4)));
      checkOutput($sformatf("rr_ack%0d", n), 32'(ack), 32'(1 << (n % 4)));
      checkOutput($sformatf("rr_gid%0d", n), 32'(grant_id), 32'(n % 4));
      checkOutput($sformatf("rr_data%0d", n), 32'(w_data), 32'(8'hA0 + (n % 4)));
      applyStimulus(4'b1111, pack4(8'hA3, 8'hA2, 8'hA1, 8'hA0), 4'b1111, 1'b0);
      checkOutput($sformatf("rr_bubble%0d", n), 32'(gnt), 32'h0);
      checkOutput($sformatf("rr_bubble_wen%0d", n), 32'(w_en), 32'h0);
    end

    $display("[TB] burst cap");
    doReset();
    applyStimulus(4'b1100, pack4(8'hD3, 8'h30, 8'h0, 8'h0), 4'b1000, 1'b0);
    checkOutput("cap_idle_busy", 32'(busy), 32'h0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b1100, pack4(8'hD3, 8'(8'h30 + k), 8'h0, 8'h0), 4'b1000, 1'b0);
      checkOutput($sformatf("cap_gnt%0d", k), 32'(gnt), 32'h4);
      checkOutput($sformatf("cap_wen%0d", k), 32'(w_en), 32'h1);
      checkOutput($sformatf("cap_ack%0d", k), 32'(ack), 32'h4);
      checkOutput($sformatf("cap_data%0d", k), 32'(w_data), 32'(8'h30 + k));
    end
    applyStimulus(4'b1100, pack4(8'hD3, 8'h38, 8'h0, 8'h0), 4'b1000, 1'b0);
    checkOutput("cap_rel_gnt", 32'(gnt), 32'h0);
    checkOutput("cap_rel_wen", 32'(w_en), 32'h0);
    applyStimulus(4'b1100, pack4(8'hD3, 8'h38, 8'h0, 8'h0), 4'b1000, 1'b0);
    checkOutput("cap_r3_gnt", 32'(gnt), 32'h8);
    checkOutput("cap_r3_ack", 32'(ack), 32'h8);
    checkOutput("cap_r3_data", 32'(w_data), 32'hD3);
    applyStimulus(4'b1100, pack4(8'hD3, 8'h38, 8'h0, 8'h0), 4'b1000, 1'b0);
    checkOutput("cap_r3_rel", 32'(gnt), 32'h0);
    applyStimulus(4'b1100, pack4(8'hD3, 8'h38, 8'h0, 8'h0), 4'b1000, 1'b0);
    checkOutput("cap_r2_resume", 32'(gnt), 32'h4);
    checkOutput("cap_r2_gid", 32'(grant_id), 32'h2);
    checkOutput("cap_r2_data", 32'(w_data), 32'h38);

    $display("[TB] full stall");
    doReset();
    applyStimulus(4'b0001, pack4(8'h0, 8'h0, 8'h0, 8'h40), 4'b0000, 1'b0);
    applyStimulus(4'b0001, pack4(8'h0, 8'h0, 8'h0, 8'h40), 4'b0000, 1'b0);
    checkOutput("st_wen0", 32'(w_en), 32'h1);
    checkOutput("st_data0", 32'(w_data), 32'h40);
    for (int s = 0; s < 5; s++) begin
      applyStimulus(4'b0001, pack4(8'h0, 8'h0, 8'h0, 8'h41), 4'b0000, 1'b1);
      checkOutput($sformatf("st_stall_wen%0d", s), 32'(w_en), 32'h0);
      checkOutput($sformatf("st_stall_ack%0d", s), 32'(ack), 32'h0);
      checkOutput($sformatf("st_stall_gnt%0d", s), 32'(gnt), 32'h1);
    end
    applyStimulus(4'b0001, pack4(8'h0, 8'h0, 8'h0, 8'h41), 4'b0000, 1'b0);
    checkOutput("st_resume_wen", 32'(w_en), 32'h1);
    checkOutput("st_resume_data", 32'(w_data), 32'h41);
    applyStimulus(4'b0001, pack4(8'h0, 8'h0, 8'h0, 8'h42), 4'b0001, 1'b0);
    checkOutput("st_last_wen", 32'(w_en), 32'h1);
    applyStimulus(4'b0000, 32'h0, 4'b0000, 1'b0);
    checkOutput("st_rel_gnt", 32'(gnt), 32'h0);
`ifdef ARB_STATS_EN
    checkOutput("st_stat_stalls", 32'(stat_stalls), 32'd5);
    checkOutput("st_stat_bursts", 32'(stat_bursts), 32'd1);
`else
    checkOutput("st_stat_stalls", 32'(stat_stalls), 32'd0);
    checkOutput("st_stat_bursts", 32'(stat_bursts), 32'd0);
`endif

    $display("[TB] abort and reset");
    doReset();
    applyStimulus(4'b0001, pack4(8'h0, 8'h0, 8'h0, 8'h50), 4'b0000, 1'b0);
    applyStimulus(4'b0001, pack4(8'h0, 8'h0, 8'h0, 8'h50), 4'b0000, 1'b0);
    checkOutput("ab_wen0", 32'(w_en), 32'h1);
    applyStimulus(4'b0001, pack4(8'h0, 8'h0, 8'h0, 8'h51), 4'b0000, 1'b0);
    checkOutput("ab_wen1", 32'(w_en), 32'h1);
    applyStimulus(4'b0000, 32'h0, 4'b0000, 1'b0);
    checkOutput("ab_drop_wen", 32'(w_en), 32'h0);
    checkOutput("ab_drop_ack", 32'(ack), 32'h0);
    applyStimulus(4'b0000, 32'h0, 4'b0000, 1'b0);
    checkOutput("ab_rel_gnt", 32'(gnt), 32'h0);
    checkOutput("ab_rel_busy", 32'(busy), 32'h0);
`ifdef ARB_STATS_EN
    checkOutput("ab_stat_bursts", 32'(stat_bursts), 32'd1);
`else
    checkOutput("ab_stat_bursts", 32'(stat_bursts), 32'd0);
`endif
    applyStimulus(4'b0100, pack4(8'h0, 8'h5A, 8'h0, 8'h0), 4'b0000, 1'b0);
    applyStimulus(4'b0100, pack4(8'h0, 8'h5A, 8'h0, 8'h0), 4'b0000, 1'b0);
    checkOutput("rs_gnt", 32'(gnt), 32'h4);
    checkOutput("rs_wen", 32'(w_en), 32'h1);
    rst = 1'b1;
    applyStimulus(4'b0101, pack4(8'h0, 8'h5A, 8'h0, 8'h5B), 4'b0000, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("rs_after_gnt", 32'(gnt), 32'h0);
    checkOutput("rs_after_busy", 32'(busy), 32'h0);
    checkOutput("rs_after_wen", 32'(w_en), 32'h0);
    checkOutput("rs_after_stat_b", 32'(stat_bursts), 32'h0);
    applyStimulus(4'b0101, pack4(8'h0, 8'h5A, 8'h0, 8'h5B), 4'b0000, 1'b0);
    checkOutput("rs_next_gnt", 32'(gnt), 32'h1);
    checkOutput("rs_next_gid", 32'(grant_id), 32'h0);

    $display("[TB] full and last together");
    doReset();
    applyStimulus(4'b0010, pack4(8'h0, 8'h0, 8'h61, 8'h0), 4'b0000, 1'b0);
    applyStimulus(4'b0010, pack4(8'h0, 8'h0, 8'h61, 8'h0), 4'b0000, 1'b0);
    checkOutput("fl_wen0", 32'(w_en), 32'h1);
    checkOutput("fl_data0", 32'(w_data), 32'h61);
    applyStimulus(4'b0010, pack4(8'h0, 8'h0, 8'h62, 8'h0), 4'b0010, 1'b1);
    checkOutput("fl_full_wen", 32'(w_en), 32'h0);
    applyStimulus(4'b0010, pack4(8'h0, 8'h0, 8'h62, 8'h0), 4'b0010, 1'b1);
    checkOutput("fl_hold_gnt", 32'(gnt), 32'h2);
    checkOutput("fl_hold_wen", 32'(w_en), 32'h0);
    applyStimulus(4'b0010, pack4(8'h0, 8'h0, 8'h62, 8'h0), 4'b0010, 1'b0);
    checkOutput("fl_last_gnt", 32'(gnt), 32'h2);
    checkOutput("fl_last_wen", 32'(w_en), 32'h1);
    checkOutput("fl_last_data", 32'(w_data), 32'h62);
    applyStimulus(4'b0000, 32'h0, 4'b0000, 1'b0);
    checkOutput("fl_rel_gnt", 32'(gnt), 32'h0);
`ifdef ARB_STATS_EN
    checkOutput("fl_stat_bursts", 32'(stat_bursts), 32'd1);
    checkOutput("fl_stat_stalls", 32'(stat_stalls), 32'd2);
`else
    checkOutput("fl_stat_bursts", 32'(stat_bursts), 32'd0);
    checkOutput("fl_stat_stalls", 32'(stat_stalls), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of the asynchronous FIFO among NUM_REQ write-side requesters. All requesters are in the w_clk domain.
- Round-robin arbitration at burst granularity. A grant is held until the requester's last word or MAX_BURST words, whichever comes first.
- Gates every write with full_flag. w_en is the increment enable for the write pointer; w_data goes to the FIFO memory write port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 8, data width per requester.
- MAX_BURST, 8, maximum words per grant (1..255).
- CW, 8, width of the burst word counter; must hold MAX_BURST.

Ports:
- w_clk  in  1  write-domain clock.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester write request; the word on req_data is valid while high.
- req_data  in  NUM_REQ*DW  packed data; requester i occupies bits [i*DW +: DW].
- req_last  in  NUM_REQ  marks the final word of requester i's packet.
- full_flag  in  1  FIFO full, already synchronized to w_clk.
- gnt  out  NUM_REQ  one-hot grant, registered.
- ack  out  NUM_REQ  word accepted from requester i this cycle.
- w_en  out  1  FIFO write enable / pointer increment.
- w_data  out  DW  selected requester's data.
- grant_id  out  3  index of the current grantee, registered.
- busy  out  1  high while in the BURST state.
- stat_bursts  out  16  completed-burst count (optional feature).
- stat_stalls  out  16  full-stall cycle count (optional feature).

Behaviour:
- Reset (synchronous on rst=1):
  - state=IDLE; gnt=0; grant_id=0; busy=0; burst counter=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Statistics counters=0.
  - Combinational outputs w_en=0 and ack=0 while state=IDLE.
- Reset mid-burst: aborts the burst. w_en is 0 from the cycle after rst is sampled.
- State IDLE:
  - If any req bit is set, select the first set bit scanning last+1, last+2, … modulo NUM_REQ.
  - Next cycle: gnt=onehot(sel), grant_id=sel, busy=1, count=0, state=BURST.
  - Request-to-grant latency is exactly 1 cycle.
  - If no req bit is set, stay in IDLE.
- State BURST, grantee g:
  - Accept condition: acc = req[g] & ~full_flag.
  - w_en = acc. ack = acc ? onehot(g) : 0. w_data = req_data[g].
  - All three are combinational from registered state and the inputs; write latency is 0 within the grant.
  - On acc, count increments.
  - Release when acc & (req_last[g] | count==MAX_BURST-1).
  - Release also when req[g]=0, which is an abort; no word is written that cycle.
  - On release, next cycle: state=IDLE, gnt=0, busy=0, last=g.
  - There is a mandatory one-cycle IDLE bubble between bursts.
  - full_flag=1 with req[g]=1 is a stall: hold the grant, w_en=0, count unchanged, no timeout.
- Boundary rules:
  - full_flag and req_last asserted together: the word is not written and the grant is not released. The word is retried when full_flag clears.
  - Only one requester active: it is regranted after each bubble. Maximum throughput is MAX_BURST words per MAX_BURST+1 cycles.
  - req bits of non-granted requesters are ignored during BURST. Their ack stays 0.
  - MAX_BURST=1: every accepted word releases the grant.
  - count wraps never; release occurs before overflow.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - stat_bursts increments by 1 on every release that includes at least one accepted word (aborts with zero words are excluded).
  - stat_stalls increments on every BURST cycle with req[g]=1 and full_flag=1.
  - Both counters saturate at 16'hFFFF and are cleared by rst.
- Not defined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Single requester, packet of 3 words: rst, then req[1]=1 with data 0x11, 0x22, 0x33 and last on the third word.
  - gnt=4'b0010 one cycle after req.
  - w_en on 3 consecutive cycles with w_data 0x11, 0x22, 0x33.
  - gnt=0 the cycle after the third word; grant_id=1.
- Round-robin fairness: req=4'b1111 held, each packet 1 word.
  - Grant order is 0, 1, 2, 3, 0 with one IDLE cycle between grants.
  - ack is one-hot matching gnt.
- Burst cap: MAX_BURST=8, requester 2 streams 12 words with no last.
  - Release after the 8th w_en.
  - If req[3] is pending, requester 3 is granted next; requester 2 resumes only after that.
- Full stall: mid-burst, full_flag=1 for 5 cycles.
  - w_en=0 and ack=0 for those cycles; gnt is held; the next word is written the cycle full_flag falls.
  - With ARB_STATS_EN, stat_stalls=5.
- Abort and reset:
  - req[0] drops after 2 words: no further w_en, gnt=0 the next cycle.
  - rst=1 during another burst: gnt, busy and w_en are 0 the following cycle; the next grant goes to requester 0.
- Full and last together: full_flag=1 on the last word of a 2-word packet.
  - The grant is held; the last word is written when full_flag=0, then released.
  - With ARB_STATS_EN, stat_bursts increments once.
